// File: rtl/instr_prefetch.sv
// Instruction-byte prefetch queue: issues sequential reads to Memory and presents {addr,data} to the Processor.
// Latency: first byte is visible 2 edges after the first strobe. Fetching stalls while queued plus in-flight bytes fill DEPTH.
module instr_prefetch #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memStrobe,
  input  logic [7:0]            memDataRead,
  output logic [7:0]            outData,
  output logic [ADDR_WIDTH-1:0] outAddr,
  output logic                  outValid,
  input  logic                  outTake,
  input  logic                  jumpEn,
  input  logic [ADDR_WIDTH-1:0] jumpAddr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [ADDR_WIDTH-1:0] fetchAddr;
  logic [CW-1:0]         count;
  logic                  inFlight;
  logic                  discard;
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [ADDR_WIDTH-1:0] entryAddr [DEPTH];
  logic [7:0]            entryData [DEPTH];
  logic                  push;
  logic                  pop;

  // The in-flight read counts as reserved space, so a push can never overflow.
  always_comb begin
    memAddr   = fetchAddr;
    memStrobe = !reset && !jumpEn && ((count + CW'(inFlight)) < DEPTH_C);
    outValid  = !reset && (count != '0);
    outData   = entryData[head];
    outAddr   = entryAddr[head];
    push      = inFlight && !discard && !jumpEn;
    pop       = outTake && outValid && !jumpEn;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchAddr <= RESET_ADDR;
      count     <= '0;
      inFlight  <= 1'b0;
      discard   <= 1'b0;
      head      <= '0;
      tail      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entryAddr[i] <= '0;
        entryData[i] <= '0;
      end
    end else begin
      inFlight <= memStrobe;
      discard  <= jumpEn && inFlight;
      if (jumpEn) begin
        fetchAddr <= jumpAddr;
        count     <= '0;
        head      <= tail;
      end else begin
        if (memStrobe)
          fetchAddr <= fetchAddr + ADDR_WIDTH'(1);
        // fetchAddr already moved past the byte now returning, so its address is one behind.
        if (push) begin
          entryAddr[tail] <= fetchAddr - ADDR_WIDTH'(1);
          entryData[tail] <= memDataRead;
          tail            <= tail + PW'(1);
        end
        if (pop)
          head <= head + PW'(1);
        if (push && !pop)
          count <= count + CW'(1);
        else if (pop && !push)
          count <= count - CW'(1);
      end
    end
  end

endmodule
